// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state type and width/bit-index constants for the elastic pipeline stage
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_RD_W   = 5;
  localparam int DEF_CTRL_W = 6;

  localparam int CTRL_REGWRITE  = 0;
  localparam int CTRL_MEMTOREG  = 1;
  localparam int CTRL_MEMREAD   = 2;
  localparam int CTRL_MEMWRITE  = 3;
  localparam int CTRL_ADD2REG   = 4;
  localparam int CTRL_BRANCHDFF = 5;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one stage entry (valid, payload, ctrl, rd); load wins over clear
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int PAY_W  = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int RD_W   = DEF_RD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [PAY_W-1:0]  in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RD_W-1:0]   in_rd,
  output logic              valid,
  output logic [PAY_W-1:0]  data,
  output logic [CTRL_W-1:0] ctrl,
  output logic [RD_W-1:0]   rd
);

  // Clear only drops valid; the payload keeps its last value to avoid toggling.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
      rd    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= in_data;
      ctrl  <= in_ctrl;
      rd    <= in_rd;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - elastic pipeline register with 2-entry skid buffer and flush
// Optional perf counters (stall_cnt, flush_cnt) enabled by PIPE_STAGE_PERF_EN.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_DATA = 4,
  parameter int CTRL_W   = DEF_CTRL_W,
  parameter int RD_W     = DEF_RD_W,
  parameter int CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [RD_W-1:0]            in_rd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [RD_W-1:0]            out_rd,
  input  logic                       flush,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt
);

  localparam int PAY_W = NUM_DATA * DATA_W;

  stage_state_t state_q, state_d;

  logic              main_valid, skid_valid;
  logic [PAY_W-1:0]  main_data, skid_data, main_src_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_src_ctrl;
  logic [RD_W-1:0]   main_rd, skid_rd, main_src_rd;
  logic              main_load, main_from_skid, main_clear, skid_load, skid_clear;
  logic              accept, drain;

  assign in_ready  = !skid_valid && !flush;
  assign accept    = in_valid && in_ready;
  assign drain     = main_valid && out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_rd    = main_valid ? main_rd : '0;

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          main_load = 1'b1;
          state_d   = ONE;
        end
        ONE: begin
          if (accept && drain) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (drain) begin
            main_clear = 1'b1;
            state_d    = EMPTY;
          end
        end
        FULL: if (drain) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clear     = 1'b1;
          state_d        = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign main_src_data = main_from_skid ? skid_data : in_data;
  assign main_src_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_src_rd   = main_from_skid ? skid_rd   : in_rd;

  pipe_slot #(.PAY_W(PAY_W), .CTRL_W(CTRL_W), .RD_W(RD_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (main_load),
    .clear   (main_clear),
    .in_data (main_src_data),
    .in_ctrl (main_src_ctrl),
    .in_rd   (main_src_rd),
    .valid   (main_valid),
    .data    (main_data),
    .ctrl    (main_ctrl),
    .rd      (main_rd)
  );

  pipe_slot #(.PAY_W(PAY_W), .CTRL_W(CTRL_W), .RD_W(RD_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (skid_load),
    .clear   (skid_clear),
    .in_data (in_data),
    .in_ctrl (in_ctrl),
    .in_rd   (in_rd),
    .valid   (skid_valid),
    .data    (skid_data),
    .ctrl    (skid_ctrl),
    .rd      (skid_rd)
  );

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  logic [CNT_W-1:0] stall_q, flush_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (main_valid && !out_ready && stall_q != '1)
        stall_q <= stall_q + CNT_ONE;
      if (flush && (main_valid || skid_valid) && flush_q != '1)
        flush_q <= flush_q + CNT_ONE;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - table vectors, corner sequences and random traffic vs a queue model
module tb_pipe_stage_skid_reg;

  localparam int DATA_W   = 64;
  localparam int NUM_DATA = 4;
  localparam int CTRL_W   = 6;
  localparam int RD_W     = 5;
  localparam int CNT_W    = 32;
  localparam int DW       = DATA_W * NUM_DATA;
  localparam int NV       = 26;

  logic              clk = 1'b0;
  logic              reset, in_valid, in_ready, out_valid, out_ready, flush;
  logic [DW-1:0]     in_data, out_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [RD_W-1:0]   in_rd, out_rd;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(
    .DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .CTRL_W(CTRL_W), .RD_W(RD_W), .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_rd     (in_rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_rd    (out_rd),
    .flush     (flush),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  typedef struct {
    logic [DW-1:0]     data;
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
  } ent_t;

  typedef struct {
    logic              rst, iv, ordy, fl;
    logic [15:0]       d0;
    logic [CTRL_W-1:0] c;
    logic [RD_W-1:0]   rd;
    logic              eov;
    logic [15:0]       ed;
    logic [CTRL_W-1:0] ec;
    logic [RD_W-1:0]   erd;
    logic              eir;
  } vec_t;

  ent_t             q[$];
  logic [CNT_W-1:0] m_stall, m_flush;
  vec_t             tbl[NV];
  int               n_vec = 0;
  int               n_err = 0;
  bit               chk_en = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, iv, ordy, fl, input logic [15:0] d0,
                              input logic [CTRL_W-1:0] c, input logic [RD_W-1:0] rd,
                              input logic eov, input logic [15:0] ed,
                              input logic [CTRL_W-1:0] ec, input logic [RD_W-1:0] erd,
                              input logic eir);
    vec_t v;
    v.rst = rst; v.iv = iv; v.ordy = ordy; v.fl = fl; v.d0 = d0; v.c = c; v.rd = rd;
    v.eov = eov; v.ed = ed; v.ec = ec; v.erd = erd; v.eir = eir;
    return v;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Drive one cycle's inputs and compare the DUT against the model's view of the stage.
  task automatic apply(input logic r, iv, ordy, fl, input logic [DW-1:0] d,
                       input logic [CTRL_W-1:0] c, input logic [RD_W-1:0] rdi);
    logic [CNT_W-1:0] es, ef;
    reset = r; in_valid = iv; out_ready = ordy; flush = fl;
    in_data = d; in_ctrl = c; in_rd = rdi;
    #1;
    if (chk_en) begin
      chk("out_valid", DW'(out_valid), DW'(q.size() != 0));
      chk("in_ready", DW'(in_ready), DW'(q.size() < 2 && !fl));
      if (q.size() != 0) begin
        chk("out_data", out_data, q[0].data);
        chk("out_ctrl", DW'(out_ctrl), DW'(q[0].ctrl));
        chk("out_rd", DW'(out_rd), DW'(q[0].rd));
      end else begin
        chk("out_ctrl_bubble", DW'(out_ctrl), '0);
        chk("out_rd_bubble", DW'(out_rd), '0);
      end
`ifdef PIPE_STAGE_PERF_EN
      es = m_stall; ef = m_flush;
`else
      es = '0; ef = '0;
`endif
      chk("stall_cnt", DW'(stall_cnt), DW'(es));
      chk("flush_cnt", DW'(flush_cnt), DW'(ef));
    end
  endtask

  // Advance one clock; the model works on a FIFO of at most two entries.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (q.size() != 0 && !out_ready && m_stall != '1) m_stall++;
      if (flush && q.size() != 0 && m_flush != '1) m_flush++;
      if (flush) begin
        q.delete();
      end else begin
        bit   acc;
        ent_t e;
        acc = in_valid && q.size() < 2;
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (acc) begin
          e.data = in_data; e.ctrl = in_ctrl; e.rd = in_rd;
          q.push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    //           rst iv or fl d0      c      rd  eov ed      ec     erd eir
    tbl[0]  = mk(0, 0, 1, 0, 16'h00, 6'h00, 0,  0, 16'h00, 6'h00, 0,  1);
    tbl[1]  = mk(0, 1, 1, 0, 16'h10, 6'h01, 1,  0, 16'h00, 6'h00, 0,  1);
    tbl[2]  = mk(0, 1, 1, 0, 16'h20, 6'h02, 2,  1, 16'h10, 6'h01, 1,  1);
    tbl[3]  = mk(0, 1, 1, 0, 16'h30, 6'h03, 3,  1, 16'h20, 6'h02, 2,  1);
    tbl[4]  = mk(0, 0, 1, 0, 16'h00, 6'h00, 0,  1, 16'h30, 6'h03, 3,  1);
    tbl[5]  = mk(0, 0, 1, 0, 16'h00, 6'h00, 0,  0, 16'h00, 6'h00, 0,  1);
    tbl[6]  = mk(0, 1, 0, 0, 16'h11, 6'h04, 4,  0, 16'h00, 6'h00, 0,  1);
    tbl[7]  = mk(0, 1, 0, 0, 16'h22, 6'h05, 5,  1, 16'h11, 6'h04, 4,  1);
    tbl[8]  = mk(0, 1, 0, 0, 16'h33, 6'h06, 6,  1, 16'h11, 6'h04, 4,  0);
    tbl[9]  = mk(0, 1, 1, 0, 16'h33, 6'h06, 6,  1, 16'h11, 6'h04, 4,  0);
    tbl[10] = mk(0, 1, 1, 0, 16'h33, 6'h06, 6,  1, 16'h22, 6'h05, 5,  1);
    tbl[11] = mk(0, 0, 1, 0, 16'h00, 6'h00, 0,  1, 16'h33, 6'h06, 6,  1);
    tbl[12] = mk(0, 0, 1, 0, 16'h00, 6'h00, 0,  0, 16'h00, 6'h00, 0,  1);
    tbl[13] = mk(0, 1, 0, 0, 16'h44, 6'h07, 7,  0, 16'h00, 6'h00, 0,  1);
    tbl[14] = mk(0, 1, 0, 0, 16'h55, 6'h08, 8,  1, 16'h44, 6'h07, 7,  1);
    tbl[15] = mk(0, 1, 0, 1, 16'h66, 6'h01, 9,  1, 16'h44, 6'h07, 7,  0);
    tbl[16] = mk(0, 0, 1, 0, 16'h00, 6'h00, 0,  0, 16'h00, 6'h00, 0,  1);
    tbl[17] = mk(0, 1, 1, 0, 16'h77, 6'h0A, 10, 0, 16'h00, 6'h00, 0,  1);
    tbl[18] = mk(0, 1, 1, 0, 16'h88, 6'h0B, 11, 1, 16'h77, 6'h0A, 10, 1);
    tbl[19] = mk(0, 0, 0, 0, 16'h00, 6'h00, 0,  1, 16'h88, 6'h0B, 11, 1);
    tbl[20] = mk(0, 0, 1, 0, 16'h00, 6'h00, 0,  1, 16'h88, 6'h0B, 11, 1);
    tbl[21] = mk(0, 1, 0, 0, 16'h99, 6'h0C, 12, 0, 16'h00, 6'h00, 0,  1);
    tbl[22] = mk(0, 1, 0, 0, 16'hAA, 6'h0D, 13, 1, 16'h99, 6'h0C, 12, 1);
    tbl[23] = mk(1, 1, 0, 0, 16'hBB, 6'h0E, 14, 1, 16'h99, 6'h0C, 12, 0);
    tbl[24] = mk(0, 0, 1, 0, 16'h00, 6'h00, 0,  0, 16'h00, 6'h00, 0,  1);
    tbl[25] = mk(0, 0, 1, 0, 16'h00, 6'h00, 0,  0, 16'h00, 6'h00, 0,  1);

    m_stall = '0;
    m_flush = '0;
    @(negedge clk);
    apply(1, 0, 0, 0, '0, '0, '0);
    tick();
    chk_en = 1'b1;
    apply(1, 0, 0, 0, '0, '0, '0);
    tick();

    for (int i = 0; i < NV; i++) begin
      apply(tbl[i].rst, tbl[i].iv, tbl[i].ordy, tbl[i].fl, DW'(tbl[i].d0), tbl[i].c, tbl[i].rd);
      chk($sformatf("tbl%0d_out_valid", i), DW'(out_valid), DW'(tbl[i].eov));
      chk($sformatf("tbl%0d_in_ready", i), DW'(in_ready), DW'(tbl[i].eir));
      chk($sformatf("tbl%0d_out_ctrl", i), DW'(out_ctrl), DW'(tbl[i].ec));
      chk($sformatf("tbl%0d_out_rd", i), DW'(out_rd), DW'(tbl[i].erd));
      if (tbl[i].eov)
        chk($sformatf("tbl%0d_lane0", i), DW'(out_data[15:0]), DW'(tbl[i].ed));
      tick();
    end

    // Five stalled cycles with a live head, then a flush while still stalled.
    apply(1, 0, 0, 0, '0, '0, '0);
    tick();
    apply(0, 1, 0, 0, DW'(16'hA5), 6'h01, 5'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 0, 0, '0, '0, '0);
      tick();
    end
    apply(0, 0, 0, 1, '0, '0, '0);
    tick();
    apply(0, 0, 1, 0, '0, '0, '0);
`ifdef PIPE_STAGE_PERF_EN
    chk("perf_stall_cnt", DW'(stall_cnt), DW'(6));
    chk("perf_flush_cnt", DW'(flush_cnt), DW'(1));
`else
    chk("perf_stall_cnt_off", DW'(stall_cnt), '0);
    chk("perf_flush_cnt_off", DW'(flush_cnt), '0);
`endif
    tick();

    for (int i = 0; i < 3000; i++) begin
      logic r, iv, ordy, fl;
      r    = ($urandom_range(0, 199) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = (i % 400 < 200) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      fl   = ($urandom_range(0, 39) == 0);
      apply(r, iv, ordy, fl, rnd_data(), 6'($urandom), 5'($urandom));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
